// File: rtl/fft8_bfly_sched.sv
// -----------------------------------------------------------------------------
// fft8_bfly_sched
//   Address/strobe scheduler for an in-place radix-2 DIT 8-point FFT
//   (bit-reversed input order). Each transform runs three stages of four
//   butterflies, one butterfly issued per cycle. A GAP of BFLY_LAT idle cycles
//   separates stages so no stage s+1 operand is read before the last stage s
//   result has been written back. Write strobes and addresses are the read
//   strobes and addresses delayed through a BFLY_LAT-deep shift register.
//
// Parameters
//   BFLY_LAT   cycles from read-address issue to result write (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request one transform (ignored while busy)
//   abort      (FFT8_SCHED_ABORT_EN only) cancel the transform in progress
//   rd_en      operand read strobe
//   rd_addr_a  operand A address   } held 0 while rd_en low
//   rd_addr_b  operand B address   }
//   tw_idx     twiddle index k of W8^k, held 0 while rd_en low
//   stage      current read stage 0..2 (0 while idle)
//   wr_en      result write strobe, rd_en delayed BFLY_LAT cycles
//   wr_addr_a  Y0 destination      } held 0 while wr_en low
//   wr_addr_b  Y1 destination      }
//   busy       transform in progress (through the final write)
//   done       one-cycle completion pulse, busy already low
//
// Build option
//   FFT8_SCHED_ABORT_EN  adds the abort input. Without it every started
//                        transform always runs to completion.
// -----------------------------------------------------------------------------
module fft8_bfly_sched #(
   parameter int unsigned BFLY_LAT = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
`ifdef FFT8_SCHED_ABORT_EN
   input  logic       abort,
`endif
   output logic       rd_en,
   output logic [2:0] rd_addr_a,
   output logic [2:0] rd_addr_b,
   output logic [1:0] tw_idx,
   output logic [1:0] stage,
   output logic       wr_en,
   output logic [2:0] wr_addr_a,
   output logic [2:0] wr_addr_b,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] LAT_M1 = 2'(BFLY_LAT - 1);

   typedef enum logic [1:0] {IDLE, RUN, GAP, FLUSH} state_t;

   typedef struct packed {
      logic       vld;
      logic [2:0] a;
      logic [2:0] b;
   } wr_ent_t;

   state_t     state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic [1:0] k_q, k_d;       // butterfly index within the stage
   logic [1:0] cnt_q, cnt_d;   // GAP / FLUSH cycle counter
   logic       done_q, done_d;
   logic       abort_w;

   wr_ent_t    wr_pipe_q [BFLY_LAT];

`ifdef FFT8_SCHED_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stage_q <= 2'd0;
         k_q     <= 2'd0;
         cnt_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            stage_d = 2'd0;
            k_d     = 2'd0;
            cnt_d   = 2'd0;
            if (start) state_d = RUN;
         end
         RUN: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               k_d     = 2'd0;
               cnt_d   = 2'd0;
               state_d = (stage_q == 2'd2) ? FLUSH : GAP;
            end
         end
         GAP: begin
            if (cnt_q == LAT_M1) begin
               cnt_d   = 2'd0;
               stage_d = stage_q + 2'd1;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         FLUSH: begin
            // Last FLUSH cycle carries the final wr_en; done follows it.
            if (cnt_q == LAT_M1) begin
               cnt_d   = 2'd0;
               stage_d = 2'd0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort_w && (state_q != IDLE)) begin
         state_d = IDLE;
         stage_d = 2'd0;
         k_d     = 2'd0;
         cnt_d   = 2'd0;
         done_d  = 1'b0;
      end
   end

   // ------------------------------------------------------- read addressing
   // span = 2^s; A = (k>>s)*2*span + (k & (span-1)), B = A + span.
   // Bit s of A is always 0, so B is A with bit s set.
   assign rd_en = (state_q == RUN);

   always_comb begin
      rd_addr_a = 3'd0;
      rd_addr_b = 3'd0;
      tw_idx    = 2'd0;
      if (rd_en) begin
         unique case (stage_q)
            2'd0: begin
               rd_addr_a = {k_q, 1'b0};
               rd_addr_b = {k_q, 1'b1};
               tw_idx    = 2'd0;
            end
            2'd1: begin
               rd_addr_a = {k_q[1], 1'b0, k_q[0]};
               rd_addr_b = {k_q[1], 1'b1, k_q[0]};
               tw_idx    = {k_q[0], 1'b0};
            end
            default: begin
               rd_addr_a = {1'b0, k_q};
               rd_addr_b = {1'b1, k_q};
               tw_idx    = k_q;
            end
         endcase
      end
   end

   // ------------------------------------------------------- write pipeline
   // Addresses enter already zeroed when rd_en is low, so the write side
   // needs no extra masking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BFLY_LAT; i++) wr_pipe_q[i] <= '0;
      end else if (abort_w && (state_q != IDLE)) begin
         for (int i = 0; i < BFLY_LAT; i++) wr_pipe_q[i] <= '0;
      end else begin
         wr_pipe_q[0] <= '{vld: rd_en, a: rd_addr_a, b: rd_addr_b};
         for (int i = 1; i < BFLY_LAT; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
      end
   end

   assign wr_en     = wr_pipe_q[BFLY_LAT-1].vld;
   assign wr_addr_a = wr_pipe_q[BFLY_LAT-1].a;
   assign wr_addr_b = wr_pipe_q[BFLY_LAT-1].b;

   assign stage = stage_q;
   assign busy  = (state_q != IDLE);
   assign done  = done_q;

endmodule

// File: tb/tb_fft8_bfly_sched.sv
// -----------------------------------------------------------------------------
// tb_fft8_bfly_sched
//   Directed bench driving two schedulers side by side (BFLY_LAT = 1 and 3).
//   Expected per-cycle outputs come from the hand-derived butterfly tables
//   below and the issue timeline: stage s occupies cycles
//   1+s*(4+L) .. 4+s*(4+L), writes trail reads by L cycles, busy spans
//   cycles 1..12+3L and done is cycle 13+3L.
// -----------------------------------------------------------------------------
module tb_fft8_bfly_sched;

   typedef struct packed {
      logic       rd;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [1:0] tw;
      logic [1:0] stg;
      logic       wr;
      logic [2:0] wa;
      logic [2:0] wb;
      logic       busy;
      logic       done;
   } obs_t;

   // Butterfly tables, stage-major, k = 0..3 within each stage.
   int ra_tab [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
   int rb_tab [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
   int tw_tab [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

   logic clk = 1'b0;
   logic rst_n, start1, start3;
   logic abort1, abort3;

   logic       rd_en1, wr_en1, busy1, done1;
   logic [2:0] rd_a1, rd_b1, wr_a1, wr_b1;
   logic [1:0] tw1, stg1;
   logic       rd_en3, wr_en3, busy3, done3;
   logic [2:0] rd_a3, rd_b3, wr_a3, wr_b3;
   logic [1:0] tw3, stg3;

   obs_t o1, o3, zo;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fft8_bfly_sched #(.BFLY_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef FFT8_SCHED_ABORT_EN
      .abort(abort1),
`endif
      .rd_en(rd_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_idx(tw1),
      .stage(stg1), .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1),
      .busy(busy1), .done(done1)
   );

   fft8_bfly_sched #(.BFLY_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef FFT8_SCHED_ABORT_EN
      .abort(abort3),
`endif
      .rd_en(rd_en3), .rd_addr_a(rd_a3), .rd_addr_b(rd_b3), .tw_idx(tw3),
      .stage(stg3), .wr_en(wr_en3), .wr_addr_a(wr_a3), .wr_addr_b(wr_b3),
      .busy(busy3), .done(done3)
   );

   assign o1 = {rd_en1, rd_a1, rd_b1, tw1, stg1, wr_en1, wr_a1, wr_b1, busy1, done1};
   assign o3 = {rd_en3, rd_a3, rd_b3, tw3, stg3, wr_en3, wr_a3, wr_b3, busy3, done3};

   // Expected outputs in cycle c of a transform whose start was sampled at
   // edge 0, for butterfly latency L.
   function automatic obs_t exp_at(input int c, input int L);
      obs_t e;
      int   p, s, k, cw;
      e = '0;
      p = 4 + L;
      if (c >= 1 && c <= 12 + 3 * L) begin
         e.busy = 1'b1;
         e.stg  = 2'((c - 1) / p);
      end
      if (c >= 1) begin
         s = (c - 1) / p;
         k = (c - 1) % p;
         if (s < 3 && k < 4) begin
            e.rd = 1'b1;
            e.ra = 3'(ra_tab[s*4+k]);
            e.rb = 3'(rb_tab[s*4+k]);
            e.tw = 2'(tw_tab[s*4+k]);
         end
      end
      cw = c - L;
      if (cw >= 1) begin
         s = (cw - 1) / p;
         k = (cw - 1) % p;
         if (s < 3 && k < 4) begin
            e.wr = 1'b1;
            e.wa = 3'(ra_tab[s*4+k]);
            e.wb = 3'(rb_tab[s*4+k]);
         end
      end
      e.done = (c == 13 + 3 * L);
      return e;
   endfunction

   task automatic chk(input string tag, input int c, input obs_t got, input obs_t exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
      end
   endtask

   initial begin
      zo     = '0;
      rst_n  = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      abort1 = 1'b0;
      abort3 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_l1", 0, o1, zo);
      chk("reset_l3", 0, o3, zo);

      // Single transform on both latencies.
      start1 = 1'b1;
      start3 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         chk("run_l1", c, o1, exp_at(c, 1));
         chk("run_l3", c, o3, exp_at(c, 3));
      end

      // start held high: ignored while busy, re-accepted in the done cycle.
      start1 = 1'b1;
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         if (c == 20) start1 = 1'b0;
         chk("hold_l1", c, o1, (c <= 16) ? exp_at(c, 1) : exp_at(c - 16, 1));
      end

      // Asynchronous reset in cycle 7, then start on the first edge after release.
      start1 = 1'b1;
      start3 = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         chk("prerst_l1", c, o1, exp_at(c, 1));
         chk("prerst_l3", c, o3, exp_at(c, 3));
      end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_l1", 7, o1, zo);
      chk("async_rst_l3", 7, o3, zo);
      for (int c = 8; c <= 10; c++) begin
         @(negedge clk);
         chk("in_rst_l1", c, o1, zo);
         chk("in_rst_l3", c, o3, zo);
      end
      rst_n  = 1'b1;
      start1 = 1'b1;
      start3 = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         start3 = 1'b0;
         chk("postrst_l1", c, o1, exp_at(c, 1));
         chk("postrst_l3", c, o3, exp_at(c, 3));
      end

`ifdef FFT8_SCHED_ABORT_EN
      // Abort sampled at edge 8: everything quiet from cycle 9, no done.
      start1 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         abort1 = 1'b0;
         chk("abort_l1", c, o1, (c <= 8) ? exp_at(c, 1) : zo);
         if (c == 8) abort1 = 1'b1;
      end
      // Abort while idle has no effect on a following start.
      abort1 = 1'b1;
      @(negedge clk);
      chk("abort_idle_l1", 0, o1, zo);
      abort1 = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("abort_idle_l1", 1, o1, exp_at(1, 1));
      repeat (16) @(negedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
